branch_predictor: RTL and testbench

Parametrised next-PC predictor for the pipelined core's fetch stage, generalising the fixed PC+4 prediction into a direct-mapped branch target buffer (BTB) with 2-bit saturating counters and a return address stack (RAS).

- Lookup is combinational on the current fetch PC and drives the predicted next PC into PC selection.
- Training comes from the decode-stage jump resolver, one resolved control-flow instruction per cycle.

---
 rtl/common.sv | 42 ++++
 rtl/branch_predictor_ras.sv | 70 +++++++
 rtl/branch_predictor.sv | 181 ++++++++++++++++++
 tb/tb_branch_predictor.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/common.sv
// Shared types and constants for the fetch-stage next-PC predictor.
package common;

  // Default geometry, used for the packed entry view below.
  localparam int DEF_XLEN    = 64;
  localparam int DEF_ENTRIES = 32;
  localparam int DEF_IDX     = $clog2(DEF_ENTRIES);

  // Counter value after reset: weakly not-taken.
  localparam logic [1:0] CTR_INIT  = 2'b01;
  // Counter value on a fresh taken-branch allocation: weakly taken.
  localparam logic [1:0] CTR_ALLOC = 2'b10;
  // Counter value for unconditional kinds.
  localparam logic [1:0] CTR_UNCOND = 2'b11;

  typedef enum logic [1:0] {
    BP_BRANCH = 2'd0,
    BP_JAL    = 2'd1,
    BP_CALL   = 2'd2,
    BP_RET    = 2'd3
  } bp_kind_t;

  typedef struct packed {
    logic                           valid;
    logic [DEF_XLEN-DEF_IDX-3:0]    tag;
    logic [DEF_XLEN-1:0]            target;
    bp_kind_t                       kind;
    logic [1:0]                     ctr;
  } btb_entry_t;

  // Two-bit saturating counter step: up on taken, down on not taken.
  function automatic logic [1:0] sat_ctr(input logic [1:0] ctr, input logic taken);
    logic [1:0] nxt;
    if (taken) begin
      nxt = (ctr == 2'b11) ? 2'b11 : ctr + 2'b01;
    end else begin
      nxt = (ctr == 2'b00) ? 2'b00 : ctr - 2'b01;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/branch_predictor_ras.sv
// Circular return address stack. When full, a push overwrites the oldest
// entry and the count saturates at DEPTH. A pop on an empty stack is ignored.
module branch_predictor_ras #(
  parameter int XLEN  = 64,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            push,
  input  logic            pop,
  input  logic [XLEN-1:0] push_data,
  output logic [XLEN-1:0] top,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTRW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNTW = $clog2(DEPTH + 1);
  localparam logic [PTRW-1:0] LAST_PTR = PTRW'(DEPTH - 1);
  localparam logic [CNTW-1:0] CNT_FULL = CNTW'(DEPTH);

  logic [XLEN-1:0] stack_q [DEPTH];
  logic [XLEN-1:0] stack_d [DEPTH];
  logic [PTRW-1:0] ptr_q, ptr_d;   // next free slot
  logic [CNTW-1:0] count_q, count_d;
  logic [PTRW-1:0] ptr_inc, ptr_dec;

  assign ptr_inc = (ptr_q == LAST_PTR) ? {PTRW{1'b0}} : ptr_q + PTRW'(1'b1);
  assign ptr_dec = (ptr_q == {PTRW{1'b0}}) ? LAST_PTR : ptr_q - PTRW'(1'b1);
  assign top     = stack_q[ptr_dec];
  assign count   = count_q;

  // Next stack contents, pointer and occupancy from push/pop.
  always_comb begin
    stack_d = stack_q;
    ptr_d   = ptr_q;
    count_d = count_q;
    if (push) begin
      stack_d[ptr_q] = push_data;
      ptr_d          = ptr_inc;
      count_d        = (count_q == CNT_FULL) ? count_q : count_q + CNTW'(1'b1);
    end else if (pop) begin
      if (count_q != {CNTW{1'b0}}) begin
        ptr_d   = ptr_dec;
        count_d = count_q - CNTW'(1'b1);
      end else begin
        ptr_d   = ptr_q;
        count_d = count_q;
      end
    end else begin
      ptr_d   = ptr_q;
      count_d = count_q;
    end
  end

  // Stack state register with synchronous active-low clear.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        stack_q[i] <= {XLEN{1'b0}};
      end
      ptr_q   <= {PTRW{1'b0}};
      count_q <= {CNTW{1'b0}};
    end else begin
      stack_q <= stack_d;
      ptr_q   <= ptr_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Next-PC predictor: direct-mapped BTB with 2-bit counters plus a return
// address stack. Lookup is purely combinational on f_pc; training arrives
// one resolved instruction per cycle and becomes visible the next cycle.
module branch_predictor #(
  parameter int XLEN      = 64,
  parameter int ENTRIES   = 32,
  parameter int RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] f_pc,
  output logic [XLEN-1:0] pred_pc,
  output logic            pred_taken,
  input  logic            upd_valid,
  input  logic [XLEN-1:0] upd_pc,
  input  logic [XLEN-1:0] upd_target,
  input  logic            upd_taken,
  input  logic [1:0]      upd_kind
);

  import common::*;

  localparam int IDX  = $clog2(ENTRIES);
  localparam int TAGW = XLEN - IDX - 2;
  localparam int CNTW = $clog2(RAS_DEPTH + 1);
  localparam logic [XLEN-1:0] PC_STEP = {{(XLEN-3){1'b0}}, 3'b100};

  // BTB storage as flop arrays so the read is combinational.
  logic            valid_q  [ENTRIES];
  logic            valid_d  [ENTRIES];
  logic [TAGW-1:0] tag_q    [ENTRIES];
  logic [TAGW-1:0] tag_d    [ENTRIES];
  logic [XLEN-1:0] target_q [ENTRIES];
  logic [XLEN-1:0] target_d [ENTRIES];
  bp_kind_t        kind_q   [ENTRIES];
  bp_kind_t        kind_d   [ENTRIES];
  logic [1:0]      ctr_q    [ENTRIES];
  logic [1:0]      ctr_d    [ENTRIES];

  logic [IDX-1:0]  f_idx, u_idx;
  logic [TAGW-1:0] f_tag, u_tag;
  logic [XLEN-1:0] f_seq, u_seq;
  logic            f_hit, u_hit;
  bp_kind_t        upd_kind_e;
  logic            ras_push, ras_pop;
  logic [XLEN-1:0] ras_top;
  logic [CNTW-1:0] ras_count;
  logic [3:0]      unused_lsbs;

  assign f_idx      = f_pc[IDX+1:2];
  assign f_tag      = f_pc[XLEN-1:IDX+2];
  assign f_seq      = f_pc + PC_STEP;       // wraps modulo 2^XLEN
  assign f_hit      = valid_q[f_idx] && (tag_q[f_idx] == f_tag);

  assign u_idx      = upd_pc[IDX+1:2];
  assign u_tag      = upd_pc[XLEN-1:IDX+2];
  assign u_seq      = upd_pc + PC_STEP;
  assign u_hit      = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
  assign upd_kind_e = bp_kind_t'(upd_kind);

  assign ras_push   = upd_valid && (upd_kind_e == BP_CALL);
  assign ras_pop    = upd_valid && (upd_kind_e == BP_RET);

  // Instruction-aligned PCs never use the low two bits.
  assign unused_lsbs = {f_pc[1:0], upd_pc[1:0]};

  branch_predictor_ras #(
    .XLEN  (XLEN),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .reset     (reset),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (u_seq),
    .top       (ras_top),
    .count     (ras_count)
  );

  // Combinational lookup: choose fall-through, BTB target or RAS top.
  always_comb begin
    pred_pc    = f_seq;
    pred_taken = 1'b0;
    if (f_hit) begin
      case (kind_q[f_idx])
        BP_BRANCH: begin
          if (ctr_q[f_idx][1]) begin
            pred_pc    = target_q[f_idx];
            pred_taken = 1'b1;
          end else begin
            pred_pc    = f_seq;
            pred_taken = 1'b0;
          end
        end
        BP_JAL, BP_CALL: begin
          pred_pc    = target_q[f_idx];
          pred_taken = 1'b1;
        end
        BP_RET: begin
          pred_taken = 1'b1;
          if (ras_count != {CNTW{1'b0}}) begin
            pred_pc = ras_top;
          end else begin
            pred_pc = target_q[f_idx];
          end
        end
        default: begin
          pred_pc    = f_seq;
          pred_taken = 1'b0;
        end
      endcase
    end else begin
      pred_pc    = f_seq;
      pred_taken = 1'b0;
    end
  end

  // Next BTB state from the resolved instruction.
  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    kind_d   = kind_q;
    ctr_d    = ctr_q;
    if (upd_valid) begin
      case (upd_kind_e)
        BP_BRANCH: begin
          if (u_hit) begin
            ctr_d[u_idx]  = sat_ctr(ctr_q[u_idx], upd_taken);
            kind_d[u_idx] = BP_BRANCH;
            if (upd_taken) begin
              target_d[u_idx] = upd_target;
            end else begin
              target_d[u_idx] = target_q[u_idx];
            end
          end else if (upd_taken) begin
            valid_d[u_idx]  = 1'b1;
            tag_d[u_idx]    = u_tag;
            target_d[u_idx] = upd_target;
            kind_d[u_idx]   = BP_BRANCH;
            ctr_d[u_idx]    = CTR_ALLOC;
          end else begin
            valid_d[u_idx]  = valid_q[u_idx];
          end
        end
        BP_JAL, BP_CALL, BP_RET: begin
          valid_d[u_idx]  = 1'b1;
          tag_d[u_idx]    = u_tag;
          target_d[u_idx] = upd_target;
          kind_d[u_idx]   = upd_kind_e;
          ctr_d[u_idx]    = CTR_UNCOND;
        end
        default: begin
          valid_d[u_idx]  = valid_q[u_idx];
        end
      endcase
    end else begin
      valid_d[u_idx] = valid_q[u_idx];
    end
  end

  // BTB register; reset wins over any concurrent update.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= {TAGW{1'b0}};
        target_q[i] <= {XLEN{1'b0}};
        kind_q[i]   <= BP_BRANCH;
        ctr_q[i]    <= CTR_INIT;
      end
    end else begin
      valid_q  <= valid_d;
      tag_q    <= tag_d;
      target_q <= target_d;
      kind_q   <= kind_d;
      ctr_q    <= ctr_d;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor (ENTRIES=32, RAS_DEPTH=4).
module tb_branch_predictor;

  import common::*;

  logic        clk;
  logic        reset;
  logic [63:0] f_pc;
  logic [63:0] pred_pc;
  logic        pred_taken;
  logic        upd_valid;
  logic [63:0] upd_pc;
  logic [63:0] upd_target;
  logic        upd_taken;
  logic [1:0]  upd_kind;

  int checks = 0;
  int errors = 0;

  branch_predictor #(
    .XLEN      (64),
    .ENTRIES   (32),
    .RAS_DEPTH (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .f_pc       (f_pc),
    .pred_pc    (pred_pc),
    .pred_taken (pred_taken),
    .upd_valid  (upd_valid),
    .upd_pc     (upd_pc),
    .upd_target (upd_target),
    .upd_taken  (upd_taken),
    .upd_kind   (upd_kind)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one resolved instruction for a single clock edge.
  task automatic do_upd(input logic [63:0] pc, input logic [63:0] tgt,
                        input logic taken, input logic [1:0] kind);
    upd_valid  = 1'b1;
    upd_pc     = pc;
    upd_target = tgt;
    upd_taken  = taken;
    upd_kind   = kind;
    @(posedge clk);
    #1;
    upd_valid  = 1'b0;
  endtask

  // Drive f_pc and compare the combinational prediction.
  task automatic check_lookup(input logic [63:0] pc, input logic [63:0] exp_pc,
                              input logic exp_taken, input string tag);
    f_pc = pc;
    #1;
    checks++;
    assert (pred_pc === exp_pc && pred_taken === exp_taken) else begin
      errors++;
      $error("FAIL %s: pred_pc=%h pred_taken=%b expected pred_pc=%h pred_taken=%b",
             tag, pred_pc, pred_taken, exp_pc, exp_taken);
    end
  endtask

  initial begin
    reset      = 1'b0;
    f_pc       = 64'h0;
    upd_valid  = 1'b0;
    upd_pc     = 64'h0;
    upd_target = 64'h0;
    upd_taken  = 1'b0;
    upd_kind   = 2'd0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;

    // Cold lookup after reset
    check_lookup(64'h8000_0000, 64'h8000_0004, 1'b0, "cold");

    // Branch training and counter hysteresis
    do_upd(64'h8000_0010, 64'h8000_0100, 1'b1, BP_BRANCH);            // ctr 2
    check_lookup(64'h8000_0010, 64'h8000_0100, 1'b1, "br_alloc");
    do_upd(64'h8000_0010, 64'h8000_0100, 1'b0, BP_BRANCH);            // ctr 1
    check_lookup(64'h8000_0010, 64'h8000_0014, 1'b0, "br_nt1");
    do_upd(64'h8000_0010, 64'h8000_0100, 1'b0, BP_BRANCH);            // ctr 0
    check_lookup(64'h8000_0010, 64'h8000_0014, 1'b0, "br_nt2");
    for (int i = 0; i < 4; i++) begin
      do_upd(64'h8000_0010, 64'h8000_0100, 1'b1, BP_BRANCH);          // 1,2,3,3
    end
    check_lookup(64'h8000_0010, 64'h8000_0100, 1'b1, "br_sat");
    do_upd(64'h8000_0010, 64'h8000_0100, 1'b0, BP_BRANCH);            // ctr 2
    check_lookup(64'h8000_0010, 64'h8000_0100, 1'b1, "br_hyst");

    // Aliasing on index 4
    check_lookup(64'h8000_0090, 64'h8000_0094, 1'b0, "alias_miss");
    do_upd(64'h8000_0090, 64'h8000_0300, 1'b0, BP_JAL);
    check_lookup(64'h8000_0090, 64'h8000_0300, 1'b1, "jal_hit");
    check_lookup(64'h8000_0010, 64'h8000_0014, 1'b0, "alias_evict");

    // RAS: RET entry trained on empty stack, then a CALL supplies the top
    do_upd(64'h8000_0204, 64'h8000_0024, 1'b0, BP_RET);               // pop no-op
    do_upd(64'h8000_0020, 64'h8000_0200, 1'b0, BP_CALL);              // push 0x24
    check_lookup(64'h8000_0020, 64'h8000_0200, 1'b1, "call_hit");
    check_lookup(64'h8000_0204, 64'h8000_0024, 1'b1, "ret_ras");
    do_upd(64'h8000_0204, 64'h8000_0024, 1'b0, BP_RET);               // count 0
    check_lookup(64'h8000_0204, 64'h8000_0024, 1'b1, "ret_empty0");

    // Five CALLs overflow the four-deep stack; newest four pop in LIFO order
    for (int i = 0; i < 5; i++) begin
      do_upd(64'h8000_3000 + 64'(16 * i), 64'h8000_5000, 1'b0, BP_CALL);
    end
    for (int k = 0; k < 4; k++) begin
      check_lookup(64'h8000_0204, 64'h8000_3044 - 64'(16 * k), 1'b1, "ret_pop");
      do_upd(64'h8000_0204, 64'h8000_0024, 1'b0, BP_RET);
    end
    check_lookup(64'h8000_0204, 64'h8000_0024, 1'b1, "ret_fallback");
    do_upd(64'h8000_0204, 64'h8000_0024, 1'b0, BP_RET);               // empty pop
    check_lookup(64'h8000_0204, 64'h8000_0024, 1'b1, "ret_fallback2");

    // Same-cycle update and lookup on one index: no bypass
    upd_valid  = 1'b1;
    upd_pc     = 64'h8000_0058;
    upd_target = 64'h8000_0800;
    upd_taken  = 1'b1;
    upd_kind   = BP_BRANCH;
    check_lookup(64'h8000_0058, 64'h8000_005C, 1'b0, "same_cycle_old");
    @(posedge clk);
    #1;
    upd_valid = 1'b0;
    check_lookup(64'h8000_0058, 64'h8000_0800, 1'b1, "same_cycle_new");

    // Reset during an update: update dropped, BTB and RAS cleared
    do_upd(64'h8000_0070, 64'h8000_0900, 1'b0, BP_CALL);
    do_upd(64'h8000_0070, 64'h8000_0900, 1'b0, BP_CALL);              // count 2
    reset      = 1'b0;
    upd_valid  = 1'b1;
    upd_pc     = 64'h8000_0060;
    upd_target = 64'h8000_0A00;
    upd_taken  = 1'b0;
    upd_kind   = BP_JAL;
    @(posedge clk);
    #1;
    reset     = 1'b1;
    upd_valid = 1'b0;
    check_lookup(64'h8000_0060, 64'h8000_0064, 1'b0, "rst_upd_drop");
    check_lookup(64'h8000_0058, 64'h8000_005C, 1'b0, "rst_btb_clear");
    do_upd(64'h8000_0204, 64'h8000_0024, 1'b0, BP_RET);
    check_lookup(64'h8000_0204, 64'h8000_0024, 1'b1, "rst_ras_clear");

    // PC+4 wraps to zero
    check_lookup(64'hFFFF_FFFF_FFFF_FFFC, 64'h0, 1'b0, "wrap");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
